// File: rtl/fifos_interface_pkg.sv
// fifos_interface_pkg
// Shared default sizing for the request/response FIFO pair.
// Contents: default depth, its log2, payload and control widths, and the
// resulting entry width, so the top and the bench agree on sizes.
package fifos_interface_pkg;

    localparam int FIFO_DEPTH_DEF         = 32;
    localparam int LOG2_FIFO_DEPTH_DEF    = 5;
    localparam int DATA_LINE_WIDTH_DEF    = 40;
    localparam int CONTROL_LINE_WIDTH_DEF = 0;
    localparam int ENTRY_WIDTH            = DATA_LINE_WIDTH_DEF + CONTROL_LINE_WIDTH_DEF;

endpackage

// File: rtl/fifos_interface_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered read port (one-cycle read latency).
// Writes while full and reads while empty are dropped; a read while empty
// leaves rd_data at its previous value. There is no write-to-read bypass.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_data, wen    write data and write enable
//   ren, rd_data    read enable and registered read data
//   empty, full     decoded from the registered occupancy count
//   overflow,       sticky dropped-write / ignored-read flags, present only
//   underflow       when FIFOS_INTERFACE_ERR_FLAGS_EN is defined
module sync_fifo #(
    parameter int DEPTH      = 32,
    parameter int LOG2_DEPTH = 5,
    parameter int WIDTH      = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wen,
    input  logic             ren,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full
);

    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Blocking is judged on the pre-edge count, so full+wen+ren reads only
    // and empty+wen+ren writes only.
    assign do_wr = wen & ~full;
    assign do_rd = ren & ~empty;

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fifos_interface.sv
// fifos_interface
// Pair of independent FIFOs between a master and a slave controller:
//   request  FIFO: master writes (mc_sreq), slave reads  (sc_rreq)
//   response FIFO: slave writes  (sc_sresp), master reads (mc_rresp)
// Entry width is DATA_LINE_WIDTH + CONTROL_LINE_WIDTH. Reads have one cycle
// of latency; writes to a full FIFO and reads of an empty FIFO are dropped.
// Optional macro FIFOS_INTERFACE_ERR_FLAGS_EN adds four sticky error outputs
// (o_mc_sreq_overflow, o_sc_rreq_underflow, o_sc_sresp_overflow,
// o_mc_rresp_underflow), cleared only by rst.
// Ports: clk, rst (async active-high); per FIFO: inbits/wen, ren/outbits,
// fifo_empty/fifo_full.
module fifos_interface
    import fifos_interface_pkg::*;
#(
    parameter int FIFO_DEPTH         = FIFO_DEPTH_DEF,
    parameter int LOG2_FIFO_DEPTH    = LOG2_FIFO_DEPTH_DEF,
    parameter int DATA_LINE_WIDTH    = DATA_LINE_WIDTH_DEF,
    parameter int CONTROL_LINE_WIDTH = CONTROL_LINE_WIDTH_DEF
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_mc_sreq_inbits,
    input  logic                                          i_mc_sreq_wen,
    output logic                                          o_mc_sreq_fifo_empty,
    output logic                                          o_mc_sreq_fifo_full,
    input  logic                                          i_sc_rreq_ren,
    output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_sc_rreq_outbits,
    input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_sc_sresp_inbits,
    input  logic                                          i_sc_sresp_wen,
    output logic                                          o_sc_sresp_fifo_empty,
    output logic                                          o_sc_sresp_fifo_full,
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
    output logic                                          o_mc_sreq_overflow,
    output logic                                          o_sc_rreq_underflow,
    output logic                                          o_sc_sresp_overflow,
    output logic                                          o_mc_rresp_underflow,
`endif
    input  logic                                          i_mc_rresp_ren,
    output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_mc_rresp_outbits
);

    localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

    sync_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH),
        .WIDTH      (W)
    ) req_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (i_mc_sreq_inbits),
        .wen       (i_mc_sreq_wen),
        .ren       (i_sc_rreq_ren),
        .rd_data   (o_sc_rreq_outbits),
        .empty     (o_mc_sreq_fifo_empty),
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
        .overflow  (o_mc_sreq_overflow),
        .underflow (o_sc_rreq_underflow),
`endif
        .full      (o_mc_sreq_fifo_full)
    );

    sync_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH),
        .WIDTH      (W)
    ) resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (i_sc_sresp_inbits),
        .wen       (i_sc_sresp_wen),
        .ren       (i_mc_rresp_ren),
        .rd_data   (o_mc_rresp_outbits),
        .empty     (o_sc_sresp_fifo_empty),
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
        .overflow  (o_sc_sresp_overflow),
        .underflow (o_mc_rresp_underflow),
`endif
        .full      (o_sc_sresp_fifo_full)
    );

endmodule

// File: tb/tb_fifos_interface.sv
// tb_fifos_interface
// Directed bench for fifos_interface: reset state, fill/overfill and drain of
// each FIFO, blocked simultaneous read/write at full and empty, mid-cycle
// reset, and (with FIFOS_INTERFACE_ERR_FLAGS_EN) the sticky error flags.
module tb_fifos_interface;
    import fifos_interface_pkg::*;

    localparam int W = ENTRY_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sreq_in  = '0;
    logic         sreq_wen = 1'b0;
    logic         sreq_empty, sreq_full;
    logic         rreq_ren = 1'b0;
    logic [W-1:0] rreq_out;
    logic [W-1:0] sresp_in  = '0;
    logic         sresp_wen = 1'b0;
    logic         sresp_empty, sresp_full;
    logic         rresp_ren = 1'b0;
    logic [W-1:0] rresp_out;
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
    logic         sreq_ovf, rreq_udf, sresp_ovf, rresp_udf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifos_interface dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_mc_sreq_inbits      (sreq_in),
        .i_mc_sreq_wen         (sreq_wen),
        .o_mc_sreq_fifo_empty  (sreq_empty),
        .o_mc_sreq_fifo_full   (sreq_full),
        .i_sc_rreq_ren         (rreq_ren),
        .o_sc_rreq_outbits     (rreq_out),
        .i_sc_sresp_inbits     (sresp_in),
        .i_sc_sresp_wen        (sresp_wen),
        .o_sc_sresp_fifo_empty (sresp_empty),
        .o_sc_sresp_fifo_full  (sresp_full),
`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
        .o_mc_sreq_overflow    (sreq_ovf),
        .o_sc_rreq_underflow   (rreq_udf),
        .o_sc_sresp_overflow   (sresp_ovf),
        .o_mc_rresp_underflow  (rresp_udf),
`endif
        .i_mc_rresp_ren        (rresp_ren),
        .o_mc_rresp_outbits    (rresp_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_req_empty",  64'(sreq_empty),  64'd1);
        chk("rst_req_full",   64'(sreq_full),   64'd0);
        chk("rst_req_out",    64'(rreq_out),    64'd0);
        chk("rst_resp_empty", 64'(sresp_empty), 64'd1);
        chk("rst_resp_full",  64'(sresp_full),  64'd0);
        chk("rst_resp_out",   64'(rresp_out),   64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Request FIFO: 70 writes of 0..69, only 0..31 accepted
        for (int i = 0; i < 70; i++) begin
            sreq_wen = 1'b1;
            sreq_in  = W'(i);
            tick();
            if (i == 30) chk("req_full_after_31", 64'(sreq_full), 64'd0);
            if (i == 31) chk("req_full_after_32", 64'(sreq_full), 64'd1);
        end
        sreq_wen = 1'b0;
        chk("req_full_after_70",  64'(sreq_full),  64'd1);
        chk("req_empty_after_70", 64'(sreq_empty), 64'd0);
        chk("resp_untouched",     64'(sresp_empty), 64'd1);

        // Request FIFO: 70 reads, 0..31 then holds 31
        for (int i = 0; i < 70; i++) begin
            rreq_ren = 1'b1;
            tick();
            chk($sformatf("req_rd%0d", i), 64'(rreq_out), (i < 32) ? 64'(i) : 64'd31);
            if (i == 30) chk("req_empty_after_31rd", 64'(sreq_empty), 64'd0);
            if (i == 31) chk("req_empty_after_32rd", 64'(sreq_empty), 64'd1);
        end
        rreq_ren = 1'b0;
        chk("req_full_drained", 64'(sreq_full), 64'd0);

        // Response FIFO: write 70..139, read 70 times
        for (int i = 0; i < 70; i++) begin
            sresp_wen = 1'b1;
            sresp_in  = W'(70 + i);
            tick();
        end
        sresp_wen = 1'b0;
        chk("resp_full",          64'(sresp_full),  64'd1);
        chk("req_empty_during",   64'(sreq_empty),  64'd1);
        chk("req_out_hold_during", 64'(rreq_out),   64'd31);
        for (int i = 0; i < 70; i++) begin
            rresp_ren = 1'b1;
            tick();
            chk($sformatf("resp_rd%0d", i), 64'(rresp_out), (i < 32) ? 64'(70 + i) : 64'd101);
        end
        rresp_ren = 1'b0;
        chk("resp_empty_drained", 64'(sresp_empty), 64'd1);
        chk("req_out_hold_after", 64'(rreq_out),    64'd31);

        // Full FIFO with simultaneous write+read: read happens, 0xAA dropped
        for (int i = 0; i < 32; i++) begin
            sreq_wen = 1'b1;
            sreq_in  = W'(100 + i);
            tick();
        end
        chk("req_full_refill", 64'(sreq_full), 64'd1);
        sreq_in  = W'(8'hAA);
        rreq_ren = 1'b1;
        tick();
        sreq_wen = 1'b0;
        chk("full_wr_rd_out",  64'(rreq_out),  64'd100);
        chk("full_wr_rd_full", 64'(sreq_full), 64'd0);
        // 31 entries remain: 101..131, with no 0xAA among them
        for (int i = 0; i < 31; i++) begin
            tick();
            chk($sformatf("drain31_rd%0d", i), 64'(rreq_out), 64'(101 + i));
            if (i == 29) chk("drain31_not_empty", 64'(sreq_empty), 64'd0);
        end
        rreq_ren = 1'b0;
        chk("drain31_empty", 64'(sreq_empty), 64'd1);

        // Empty FIFO with simultaneous write+read: write happens, read ignored
        sreq_wen = 1'b1;
        rreq_ren = 1'b1;
        sreq_in  = W'(8'h55);
        tick();
        sreq_wen = 1'b0;
        chk("empty_wr_rd_out",   64'(rreq_out),   64'd131);
        chk("empty_wr_rd_empty", 64'(sreq_empty), 64'd0);
        tick();
        rreq_ren = 1'b0;
        chk("empty_wr_rd_next", 64'(rreq_out),   64'h55);
        chk("empty_wr_rd_done", 64'(sreq_empty), 64'd1);

        // Mid-cycle reset discards queued entries
        for (int i = 0; i < 5; i++) begin
            sreq_wen  = 1'b1;
            sreq_in   = W'(i + 1);
            sresp_wen = 1'b1;
            sresp_in  = W'(i + 11);
            tick();
        end
        sreq_wen  = 1'b0;
        sresp_wen = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_empty",  64'(sreq_empty),  64'd1);
        chk("midrst_req_full",   64'(sreq_full),   64'd0);
        chk("midrst_req_out",    64'(rreq_out),    64'd0);
        chk("midrst_resp_empty", 64'(sresp_empty), 64'd1);
        chk("midrst_resp_out",   64'(rresp_out),   64'd0);
        tick();
        rst = 1'b0;
        sreq_wen = 1'b1;
        sreq_in  = W'(7);
        tick();
        sreq_wen = 1'b0;
        rreq_ren = 1'b1;
        tick();
        rreq_ren = 1'b0;
        chk("post_rst_rd",    64'(rreq_out),   64'd7);
        chk("post_rst_empty", 64'(sreq_empty), 64'd1);

`ifdef FIFOS_INTERFACE_ERR_FLAGS_EN
        chk("flag_ovf_clear", 64'(sreq_ovf),  64'd0);
        chk("flag_udf_clear", 64'(rresp_udf), 64'd0);
        for (int i = 0; i < 32; i++) begin
            sreq_wen = 1'b1;
            sreq_in  = W'(i);
            tick();
        end
        chk("flag_ovf_at_32", 64'(sreq_ovf), 64'd0);
        tick();
        sreq_wen = 1'b0;
        chk("flag_ovf_at_33", 64'(sreq_ovf), 64'd1);
        rresp_ren = 1'b1;
        tick();
        rresp_ren = 1'b0;
        chk("flag_udf_set", 64'(rresp_udf), 64'd1);
        tick();
        tick();
        chk("flag_ovf_sticky", 64'(sreq_ovf),  64'd1);
        chk("flag_udf_sticky", 64'(rresp_udf), 64'd1);
        chk("flag_rreq_udf",   64'(rreq_udf),  64'd0);
        chk("flag_sresp_ovf",  64'(sresp_ovf), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("flag_ovf_rst", 64'(sreq_ovf),  64'd0);
        chk("flag_udf_rst", 64'(rresp_udf), 64'd0);
        tick();
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifos_interface.md
FIFOS_INTERFACE -- requirements
Module: fifos_interface

Interface
REQ-001 Parameter FIFO_DEPTH, 32, entries per FIFO (power of two, >=2).
REQ-002 Parameter LOG2_FIFO_DEPTH, 5, log2(FIFO_DEPTH).
REQ-003 Parameter DATA_LINE_WIDTH, 40, payload bits per entry.
REQ-004 Parameter CONTROL_LINE_WIDTH, 0, control bits per entry; entry width W = DATA_LINE_WIDTH+CONTROL_LINE_WIDTH.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 i_mc_sreq_inbits  in  W  master send-request write data.
REQ-009 i_mc_sreq_wen  in  1  request FIFO write enable.
REQ-010 o_mc_sreq_fifo_empty  out  1  request FIFO holds 0 entries.
REQ-011 o_mc_sreq_fifo_full  out  1  request FIFO holds FIFO_DEPTH entries.
REQ-012 i_sc_rreq_ren  in  1  slave receive-request read enable.
REQ-013 o_sc_rreq_outbits  out  W  request FIFO read data.
REQ-014 i_sc_sresp_inbits  in  W  slave send-response write data.
REQ-015 i_sc_sresp_wen  in  1  response FIFO write enable.
REQ-016 o_sc_sresp_fifo_empty  out  1  response FIFO holds 0 entries.
REQ-017 o_sc_sresp_fifo_full  out  1  response FIFO holds FIFO_DEPTH entries.
REQ-018 i_mc_rresp_ren  in  1  master receive-response read enable.
REQ-019 o_mc_rresp_outbits  out  W  response FIFO read data.

Function
REQ-020 Two independent identical synchronous FIFOs SHALL exist: request (mc_sreq write -> sc_rreq read) and response (sc_sresp write -> mc_rresp read).
REQ-021 Each FIFO SHALL keep write pointer, read pointer (LOG2_FIFO_DEPTH bits, wrap modulo FIFO_DEPTH) and occupancy count (LOG2_FIFO_DEPTH+1 bits).
REQ-022 Write with wen=1 and not full SHALL store inbits at write pointer on the clk edge and advance the pointer.
REQ-023 Write while full SHALL be dropped; contents, pointers, count unchanged.
REQ-024 Read with ren=1 and not empty SHALL register the head entry onto outbits at the clk edge (one-cycle latency) and advance the read pointer.
REQ-025 Read while empty SHALL be ignored; outbits holds its previous value.
REQ-026 Simultaneous write and read when neither blocked SHALL both occur; count unchanged.
REQ-027 When full, simultaneous write+read: read occurs, write dropped (full evaluated pre-edge).
REQ-028 When empty, simultaneous write+read: write occurs, read ignored (no bypass).
REQ-029 empty = (count==0), full = (count==FIFO_DEPTH), both decoded combinationally from registered count.
REQ-030 Data SHALL emerge in write order; no entry duplicated or lost except dropped writes.

Reset
REQ-031 rst=1 SHALL immediately clear pointers and counts of both FIFOs: empty=1, full=0, outbits=0; storage array need not be cleared.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; first post-reset read returns the first post-reset write.

Configuration
REQ-033 Macro FIFOS_INTERFACE_ERR_FLAGS_EN defined: add outputs o_mc_sreq_overflow, o_sc_rreq_underflow, o_sc_sresp_overflow, o_mc_rresp_underflow, each a sticky bit set on a dropped write (REQ-023/027) or ignored read (REQ-025/028), cleared only by rst.
REQ-034 Macro undefined: those ports and logic are absent; all other behaviour is identical.

Structure
REQ-035 Package fifos_interface_pkg SHALL hold default width/depth constants and the entry-width localparam.
REQ-036 One sub-module sync_fifo (parameterised depth/width) SHALL be instantiated twice.

Verification
REQ-037 Reset, then 70 request writes of values 0..69 -> full=1 after 32nd write, entries 0..31 stored, 32..69 dropped, empty=0.
REQ-038 Then 70 request reads -> outbits 0..31 in order one cycle after each ren, empty=1 after 32nd, outbits holds 31 thereafter.
REQ-039 Response FIFO: write 70..139, then read 70 -> outbits 70..101, then holds 101; request FIFO unaffected throughout.
REQ-040 Fill to 32, assert wen+ren one cycle with value 0xAA -> one entry read, 0xAA dropped, count 31; at empty, wen+ren with 0x55 -> count 1, next read returns 0x55.
REQ-041 Write 5 entries, assert rst mid-cycle -> empty=1, full=0, outbits=0 immediately; write 0x7 then read -> 0x7.
REQ-042 With FIFOS_INTERFACE_ERR_FLAGS_EN: write 33 entries -> o_mc_sreq_overflow=1 and stays set until rst; read empty response FIFO -> o_mc_rresp_underflow=1.
